data_memory_bhw: RTL
====================

# data_memory_bhw

Parametrised data memory for the RISC-V single-cycle core: the next generation of the word-only data RAM. It adds byte/halfword/word stores, sign- and zero-extending loads decoded from funct3, a configurable depth, misalignment detection and a self-clearing sequencer. The sequencer zeroes the array one word per cycle after reset instead of in a single cycle. It sits between the ALU result/rs2 path and the write-back mux. The core stalls on `init_busy`.

## Interface
- DEPTH, 64: number of 32-bit words; power of two, ≥ 2.
- IDX_W, $clog2(DEPTH): word-index width (derived; do not override).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk.
- MemWrite  in  1  store request this cycle.
- MemRead  in  1  load request this cycle.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (rs2); low byte/half used for SB/SH.
- read_data  out  32  load result, extended to 32 bits.
- misaligned  out  1  access violates natural alignment.
- init_busy  out  1  clear sequencer running; memory unavailable.

## Operation
- Word index = address[IDX_W+1:2]. Byte lane = address[1:0]. Higher address bits are ignored, so accesses wrap modulo DEPTH*4 bytes.
- FSM states: CLEAR, READY.
  - reset=1 in any state → CLEAR, clear_ptr←0.
  - CLEAR, reset=0: write 0 to mem[clear_ptr], then clear_ptr++. Write to mem[DEPTH-1] → READY.
  - READY holds until reset.
- init_busy = (state==CLEAR).
- In CLEAR: MemWrite ignored, read_data=0, misaligned=0.
- Stores (READY, MemWrite=1, not misaligned):
  - SB writes byte lane address[1:0] with write_data[7:0].
  - SH writes lanes {address[1],0} and {address[1],1} with write_data[15:0], little-endian.
  - SW writes the full word.
  - Other lanes are unchanged.
  - funct3 ∉ {000,001,010}: no write.
- Loads (READY, MemRead=1, not misaligned):
  - LB/LH sign-extend the selected byte/half.
  - LBU/LHU zero-extend.
  - LW returns the word.
  - Unsupported funct3 returns 0.
  - MemRead=0 returns 0.
- Misalignment:
  - H/HU with address[0]=1 is misaligned.
  - W with address[1:0]≠0 is misaligned.
  - Byte accesses are never misaligned.
  - misaligned = (MemRead|MemWrite) & condition & READY.
  - A misaligned store writes nothing. A misaligned load returns 0.
- Simultaneous MemRead and MemWrite to the same word: read_data shows pre-write contents. The new data is visible after the edge.

## Timing
- Read path is combinational, zero latency: read_data and misaligned follow the inputs within the same cycle.
- Store commits on the rising edge where MemWrite=1 and state==READY.
- Reset asserted at edge k:
  - state=CLEAR, clear_ptr=0 and init_busy=1 from edge k.
  - read_data=0 and misaligned=0 while init_busy.
  - A store presented in the reset cycle is dropped.
- With reset held, each edge rewrites mem[0]=0 and clear_ptr stays 0.
- After reset deasserts, clearing takes exactly DEPTH edges. init_busy falls after the edge that writes mem[DEPTH-1]. The first store is accepted on the next edge.
- Reset during CLEAR restarts clearing from index 0. Reset during READY discards contents via the full clear.
- clear_ptr is IDX_W bits; the terminal compare is against DEPTH-1, so no wrap occurs.

## Test plan
- Clear timing (DEPTH=64): reset 1 cycle, then low → init_busy=1 for exactly 64 cycles. Afterwards LW at 0x00, 0x7C, 0xFC reads 0.
- Byte/half stores: SW 0x11223344 @0x10, SB 0xAA @0x11, SH 0xBEEF @0x12 → LW @0x10 = 0xBEEFAA44. LB @0x11 = 0xFFFFFFAA. LBU @0x11 = 0x000000AA. LH @0x12 = 0xFFFFBEEF. LHU @0x12 = 0x0000BEEF.
- Misalignment: SW 0xDEADBEEF @0x21 → misaligned=1 and word 0x20 remains 0. LH @0x23 → misaligned=1 and read_data=0. LB @0x23 → misaligned=0.
- Read-during-write: word 0x30 = 0x5, then in one cycle MemRead=MemWrite=1, SW 0x9 → read_data=0x5 that cycle and 0x9 the next.
- Wrap and busy: SW 0x77 @0x104 (DEPTH=64) → LW @0x04 = 0x77. SW issued while init_busy=1 → no effect.
- Mid-clear reset: reset at clear cycle 30 → init_busy stays high for 64 further cycles after deassert, and all words read 0.

Source files
------------

// File: rtl/data_memory_bhw.sv
// Byte/halfword/word data RAM for the single-cycle RISC-V core.
// After reset a sequencer zeroes one word per cycle; init_busy stalls the core meanwhile.
module data_memory_bhw #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        init_busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  state_t           state, state_next;
  logic [IDX_W-1:0] clear_ptr, clear_ptr_next;
  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [31:0]      word;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             mis_cond;
  logic             ready;
  logic [3:0]       lane_en;
  logic [31:0]      store_word;
  logic             store_en;
  logic             addr_unused;

  assign idx         = address[IDX_W+1:2];
  assign lane        = address[1:0];
  assign addr_unused = ^address[31:IDX_W+2];
  assign ready       = (state == READY);
  assign init_busy   = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clear_ptr <= '0;
    end else begin
      state     <= state_next;
      clear_ptr <= clear_ptr_next;
    end
  end

  always_comb begin
    state_next     = state;
    clear_ptr_next = clear_ptr;
    case (state)
      CLEAR: begin
        clear_ptr_next = clear_ptr + 1'b1;
        if (clear_ptr == IDX_W'(DEPTH - 1)) begin
          state_next     = READY;
          clear_ptr_next = '0;
        end
      end
      default: state_next = READY;
    endcase
  end

  always_comb begin
    mis_cond = 1'b0;
    case (funct3)
      F_H, F_HU: mis_cond = address[0];
      F_W:       mis_cond = (lane != 2'b00);
      default:   mis_cond = 1'b0;
    endcase
  end

  assign misaligned = (MemRead | MemWrite) & mis_cond & ready;

  assign word     = mem[idx];
  assign byte_sel = 8'(word >> {lane, 3'b000});
  assign half_sel = address[1] ? word[31:16] : word[15:0];

  always_comb begin
    read_data = '0;
    if (ready && MemRead && !mis_cond) begin
      case (funct3)
        F_B:     read_data = {{24{byte_sel[7]}}, byte_sel};
        F_H:     read_data = {{16{half_sel[15]}}, half_sel};
        F_W:     read_data = word;
        F_BU:    read_data = {24'd0, byte_sel};
        F_HU:    read_data = {16'd0, half_sel};
        default: read_data = '0;
      endcase
    end
  end

  // Data is replicated across lanes so lane_en alone picks what lands where.
  always_comb begin
    lane_en    = 4'b0000;
    store_word = write_data;
    case (funct3)
      F_B: begin
        lane_en    = 4'b0001 << lane;
        store_word = {4{write_data[7:0]}};
      end
      F_H: begin
        lane_en    = address[1] ? 4'b1100 : 4'b0011;
        store_word = {2{write_data[15:0]}};
      end
      F_W: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  assign store_en = ready & MemWrite & ~mis_cond;

  // Reset held in any state keeps rewriting word 0, matching clear_ptr stuck at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
    end else if (state == CLEAR) begin
      mem[clear_ptr] <= '0;
    end else if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

endmodule
